// File: rtl/tap_sel_if.sv
// TAP-select bundle between the strap/host pads and the TAP IO mux.
// master: pad side driving the request and host TMS; slave: the sequencer.
interface tap_sel_if;
  logic [1:0] pad_sel_tap;
  logic       pad_tap_tms;
  logic [1:0] sel_tap_out;
  logic       tms_out;
  logic       busy;
  logic       forced_park;
  logic [3:0] shadow_state;

  modport master (
    output pad_sel_tap,
    output pad_tap_tms,
    input  sel_tap_out,
    input  tms_out,
    input  busy,
    input  forced_park,
    input  shadow_state
  );

  modport slave (
    input  pad_sel_tap,
    input  pad_tap_tms,
    output sel_tap_out,
    output tms_out,
    output busy,
    output forced_park,
    output shadow_state
  );
endinterface

// File: rtl/tap_sel_ctrl.sv
// Safe-switch sequencer for JTAG TAP selection: waits for the active TAP to idle,
// parks both TAPs in Test-Logic-Reset, then flips the mux select.
module tap_sel_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARK_CYCLES = 5,
  parameter int unsigned WAIT_MAX    = 64
) (
  input  logic     tap_tck,
  input  logic     tap_trst_n,
  tap_sel_if.slave bus
);
  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);
  localparam int unsigned ParkW = $clog2(PARK_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);
  localparam logic [ParkW-1:0] ParkLast = ParkW'(PARK_CYCLES - 1);
  localparam logic [3:0] Tlr = 4'hF;
  localparam logic [3:0] Rti = 4'hC;

  typedef enum logic [1:0] {StActive, StWaitSafe, StPark} state_e;

  state_e                        state;
  logic [SYNC_STAGES-1:0][1:0]   sync;
  logic [1:0]                    sel_sync;
  logic [1:0]                    target;
  logic [1:0]                    sel_tap;
  logic [3:0]                    shadow;
  logic                          switching;
  logic                          forced;
  logic [WaitW-1:0]              wait_cnt;
  logic [ParkW-1:0]              park_cnt;
  logic                          tms;
  logic                          class_diff;

  // IEEE 1149.1 TAP controller next-state.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    logic [3:0] nxt;
    nxt = s;
    unique case (s)
      4'hF: nxt = t ? 4'hF : 4'hC;
      4'hC: nxt = t ? 4'h7 : 4'hC;
      4'h7: nxt = t ? 4'h4 : 4'h6;
      4'h6: nxt = t ? 4'h1 : 4'h2;
      4'h2: nxt = t ? 4'h1 : 4'h2;
      4'h1: nxt = t ? 4'h5 : 4'h3;
      4'h3: nxt = t ? 4'h0 : 4'h3;
      4'h0: nxt = t ? 4'h5 : 4'h2;
      4'h5: nxt = t ? 4'h7 : 4'hC;
      4'h4: nxt = t ? 4'hF : 4'hE;
      4'hE: nxt = t ? 4'h9 : 4'hA;
      4'hA: nxt = t ? 4'h9 : 4'hA;
      4'h9: nxt = t ? 4'hD : 4'hB;
      4'hB: nxt = t ? 4'h8 : 4'hB;
      4'h8: nxt = t ? 4'hD : 4'hA;
      4'hD: nxt = t ? 4'h7 : 4'hC;
    endcase
    return nxt;
  endfunction

  assign sel_sync   = sync[SYNC_STAGES-1];
  assign class_diff = (|sel_sync) != (|sel_tap);
  // TMS the TAPs actually see; held high in reset so both TAPs reset with us.
  assign tms        = !tap_trst_n || (state == StPark) || bus.pad_tap_tms;

  assign bus.tms_out      = tms;
  assign bus.sel_tap_out  = sel_tap;
  assign bus.busy         = switching;
  assign bus.forced_park  = forced;
  assign bus.shadow_state = shadow;

  always_ff @(posedge tap_tck) begin
    if (!tap_trst_n) begin
      state     <= StActive;
      sync      <= '0;
      target    <= 2'b00;
      sel_tap   <= 2'b00;
      shadow    <= Tlr;
      switching <= 1'b0;
      forced    <= 1'b0;
      wait_cnt  <= '0;
      park_cnt  <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.pad_sel_tap};
      shadow <= tap_next(shadow, tms);
      unique case (state)
        StActive: begin
          if (sel_sync != sel_tap) begin
            if (class_diff) begin
              state     <= StWaitSafe;
              target    <= sel_sync;
              switching <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              // Same mux routing, so the code can change without parking.
              sel_tap <= sel_sync;
            end
          end
        end
        StWaitSafe: begin
          if (!class_diff) begin
            state     <= StActive;
            switching <= 1'b0;
          end else if (shadow == Tlr || shadow == Rti) begin
            state    <= StPark;
            park_cnt <= '0;
          end else if (wait_cnt == WaitLast) begin
            state    <= StPark;
            park_cnt <= '0;
            forced   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        StPark: begin
          if (park_cnt == ParkLast) begin
            sel_tap   <= target;
            shadow    <= Tlr;
            state     <= StActive;
            switching <= 1'b0;
          end else begin
            park_cnt <= park_cnt + ParkW'(1);
          end
        end
        default: state <= StActive;
      endcase
    end
  end
endmodule

// File: tb/tb_tap_sel_ctrl.sv
// Bench for tap_sel_ctrl: shadow-state vector table, directed switch sequences and
// randomized traffic, all checked against a cycle-level reference model.
module tb_tap_sel_ctrl;
  localparam int SYNC  = 2;
  localparam int PARK  = 5;
  localparam int WAITM = 64;

  logic tap_tck;
  logic tap_trst_n;
  tap_sel_if bus ();

  tap_sel_ctrl #(
    .SYNC_STAGES(SYNC),
    .PARK_CYCLES(PARK),
    .WAIT_MAX   (WAITM)
  ) dut (
    .tap_tck   (tap_tck),
    .tap_trst_n(tap_trst_n),
    .bus       (bus)
  );

  initial tap_tck = 1'b0;
  always #5 tap_tck = ~tap_tck;

  int checks = 0;
  int errors = 0;

  // Reference TAP transition tables indexed by state encoding.
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];

  // Reference model state. phase: 0 idle, 1 waiting for a safe state, 2 parking.
  logic [1:0] m_line [SYNC];
  logic [1:0] m_sel, m_target;
  logic       m_busy, m_forced;
  logic [3:0] m_shadow;
  int         m_phase, m_waited, m_parked;

  typedef struct {
    logic       tms;
    logic [3:0] shadow;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic init_tables();
    nxt0[15] = 4'hC; nxt1[15] = 4'hF;  // TLR
    nxt0[12] = 4'hC; nxt1[12] = 4'h7;  // RTI
    nxt0[7]  = 4'h6; nxt1[7]  = 4'h4;  // SelDR
    nxt0[6]  = 4'h2; nxt1[6]  = 4'h1;  // CapDR
    nxt0[2]  = 4'h2; nxt1[2]  = 4'h1;  // ShDR
    nxt0[1]  = 4'h3; nxt1[1]  = 4'h5;  // Ex1DR
    nxt0[3]  = 4'h3; nxt1[3]  = 4'h0;  // PauseDR
    nxt0[0]  = 4'h2; nxt1[0]  = 4'h5;  // Ex2DR
    nxt0[5]  = 4'hC; nxt1[5]  = 4'h7;  // UpdDR
    nxt0[4]  = 4'hE; nxt1[4]  = 4'hF;  // SelIR
    nxt0[14] = 4'hA; nxt1[14] = 4'h9;  // CapIR
    nxt0[10] = 4'hA; nxt1[10] = 4'h9;  // ShIR
    nxt0[9]  = 4'hB; nxt1[9]  = 4'hD;  // Ex1IR
    nxt0[11] = 4'hB; nxt1[11] = 4'h8;  // PauseIR
    nxt0[8]  = 4'hA; nxt1[8]  = 4'hD;  // Ex2IR
    nxt0[13] = 4'hC; nxt1[13] = 4'h7;  // UpdIR
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_line[i] = 2'b00;
    m_sel = 2'b00; m_target = 2'b00; m_busy = 1'b0; m_forced = 1'b0;
    m_shadow = 4'hF; m_phase = 0; m_waited = 0; m_parked = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [1:0] req;
    logic       tms_eff;
    logic [3:0] nxt;
    bit         diff;
    if (!tap_trst_n) begin
      model_reset();
      return;
    end
    req     = m_line[SYNC-1];
    tms_eff = (m_phase == 2) ? 1'b1 : bus.pad_tap_tms;
    nxt     = tms_eff ? nxt1[m_shadow] : nxt0[m_shadow];
    diff    = ((req != 2'b00) != (m_sel != 2'b00));
    case (m_phase)
      0: begin
        if (req != m_sel) begin
          if (diff) begin
            m_phase = 1; m_target = req; m_busy = 1'b1; m_waited = 0;
          end else begin
            m_sel = req;
          end
        end
      end
      1: begin
        if (!diff) begin
          m_phase = 0; m_busy = 1'b0;
        end else if (m_shadow == 4'hF || m_shadow == 4'hC) begin
          m_phase = 2; m_parked = 0;
        end else begin
          m_waited++;
          if (m_waited == WAITM) begin
            m_phase = 2; m_parked = 0; m_forced = 1'b1;
          end
        end
      end
      default: begin
        m_parked++;
        if (m_parked == PARK) begin
          m_sel = m_target; nxt = 4'hF; m_phase = 0; m_busy = 1'b0;
        end
      end
    endcase
    for (int i = SYNC - 1; i > 0; i--) m_line[i] = m_line[i-1];
    m_line[0] = bus.pad_sel_tap;
    m_shadow  = nxt;
  endtask

  task automatic tick();
    logic exp_tms;
    model_step();
    @(posedge tap_tck);
    #1;
    exp_tms = (!tap_trst_n || m_phase == 2) ? 1'b1 : bus.pad_tap_tms;
    check("model_sel",    {6'd0, bus.sel_tap_out}, {6'd0, m_sel});
    check("model_busy",   {7'd0, bus.busy},        {7'd0, m_busy});
    check("model_forced", {7'd0, bus.forced_park}, {7'd0, m_forced});
    check("model_shadow", {4'd0, bus.shadow_state}, {4'd0, m_shadow});
    check("model_tms",    {7'd0, bus.tms_out},     {7'd0, exp_tms});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    tap_trst_n      = 1'b0;
    bus.pad_sel_tap = 2'b00;
    bus.pad_tap_tms = 1'b0;
    tick();
    check("rst_sel",    {6'd0, bus.sel_tap_out}, 8'h00);
    check("rst_busy",   {7'd0, bus.busy},        8'h00);
    check("rst_forced", {7'd0, bus.forced_park}, 8'h00);
    check("rst_shadow", {4'd0, bus.shadow_state}, 8'h0F);
    check("rst_tms",    {7'd0, bus.tms_out},     8'h01);
    tap_trst_n = 1'b1;
  endtask

  // From TLR with TMS 0,1,0,0 the TAP lands in ShDR.
  task automatic goto_shdr();
    bus.pad_tap_tms = 1'b0; tick();
    bus.pad_tap_tms = 1'b1; tick();
    bus.pad_tap_tms = 1'b0; tick();
    tick();
    check("shdr_reached", {4'd0, bus.shadow_state}, 8'h02);
  endtask

  task automatic wait_park(input int budget);
    int n = 0;
    while (bus.tms_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("park_reached", {7'd0, bus.tms_out}, 8'h01);
  endtask

  initial begin
    logic [1:0] bits;
    int         mode;
    init_tables();
    model_reset();
    tap_trst_n      = 1'b0;
    bus.pad_sel_tap = 2'b00;
    bus.pad_tap_tms = 1'b0;

    // Shadow table: visits all 16 states, then five ones from ShIR park in TLR.
    bits = 2'b00;
    vecs.push_back('{1'b0, 4'hC}); vecs.push_back('{1'b1, 4'h7});
    vecs.push_back('{1'b0, 4'h6}); vecs.push_back('{1'b0, 4'h2});
    vecs.push_back('{1'b1, 4'h1}); vecs.push_back('{1'b0, 4'h3});
    vecs.push_back('{1'b1, 4'h0}); vecs.push_back('{1'b0, 4'h2});
    vecs.push_back('{1'b1, 4'h1}); vecs.push_back('{1'b1, 4'h5});
    vecs.push_back('{1'b1, 4'h7}); vecs.push_back('{1'b1, 4'h4});
    vecs.push_back('{1'b0, 4'hE}); vecs.push_back('{1'b1, 4'h9});
    vecs.push_back('{1'b0, 4'hB}); vecs.push_back('{1'b1, 4'h8});
    vecs.push_back('{1'b0, 4'hA}); vecs.push_back('{1'b1, 4'h9});
    vecs.push_back('{1'b1, 4'hD}); vecs.push_back('{1'b1, 4'h7});
    vecs.push_back('{1'b1, 4'h4}); vecs.push_back('{1'b1, 4'hF});
    vecs.push_back('{1'b0, 4'hC}); vecs.push_back('{1'b1, 4'h7});
    vecs.push_back('{1'b1, 4'h4}); vecs.push_back('{1'b0, 4'hE});
    vecs.push_back('{1'b0, 4'hA}); vecs.push_back('{1'b1, 4'h9});
    vecs.push_back('{1'b1, 4'hD}); vecs.push_back('{1'b1, 4'h7});
    vecs.push_back('{1'b1, 4'h4}); vecs.push_back('{1'b1, 4'hF});

    do_reset();
    foreach (vecs[i]) begin
      bus.pad_tap_tms = vecs[i].tms;
      tick();
      check("vec_shadow", {4'd0, bus.shadow_state}, {4'd0, vecs[i].shadow});
      check("vec_tms",    {7'd0, bus.tms_out},     {7'd0, vecs[i].tms});
    end

    // Idle switch 00 -> 10 with the TAP in RTI.
    do_reset();
    tick();
    bus.pad_sel_tap = 2'b10;
    ticks(2);
    check("idle_busy_early", {7'd0, bus.busy}, 8'h00);
    tick();
    check("idle_busy_rise", {7'd0, bus.busy}, 8'h01);
    tick();
    check("idle_park_tms", {7'd0, bus.tms_out}, 8'h01);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 5) begin
        check("idle_park_sel", {6'd0, bus.sel_tap_out}, 8'h00);
        check("idle_park_tms", {7'd0, bus.tms_out}, 8'h01);
      end
    end
    check("idle_commit_sel",    {6'd0, bus.sel_tap_out}, 8'h02);
    check("idle_commit_busy",   {7'd0, bus.busy}, 8'h00);
    check("idle_commit_shadow", {4'd0, bus.shadow_state}, 8'h0F);
    check("idle_commit_forced", {7'd0, bus.forced_park}, 8'h00);

    // Same-class change 10 -> 01: no park, busy stays low.
    ticks(3);
    bus.pad_sel_tap = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("same_busy", {7'd0, bus.busy}, 8'h00);
    end
    check("same_sel", {6'd0, bus.sel_tap_out}, 8'h01);

    // Mid-shift: wait until the host walks ShDR -> Ex1DR -> UpdDR -> RTI.
    do_reset();
    goto_shdr();
    bus.pad_sel_tap = 2'b01;
    ticks(3);
    check("mid_busy", {7'd0, bus.busy}, 8'h01);
    bus.pad_tap_tms = 1'b1;
    #1;
    check("mid_tms_follow", {7'd0, bus.tms_out}, 8'h01);
    ticks(2);
    bus.pad_tap_tms = 1'b0;
    tick();
    check("mid_rti", {4'd0, bus.shadow_state}, 8'h0C);
    check("mid_not_parked", {7'd0, bus.tms_out}, 8'h00);
    tick();
    check("mid_park", {7'd0, bus.tms_out}, 8'h01);
    ticks(4);
    check("mid_sel_hold", {6'd0, bus.sel_tap_out}, 8'h00);
    tick();
    check("mid_sel_flip", {6'd0, bus.sel_tap_out}, 8'h01);

    // Timeout: shadow stuck in ShDR forces a park after WAIT_MAX edges.
    do_reset();
    goto_shdr();
    bus.pad_sel_tap = 2'b10;
    ticks(3);
    check("to_busy", {7'd0, bus.busy}, 8'h01);
    ticks(WAITM - 1);
    check("to_forced_early", {7'd0, bus.forced_park}, 8'h00);
    check("to_tms_early",    {7'd0, bus.tms_out}, 8'h00);
    tick();
    check("to_forced", {7'd0, bus.forced_park}, 8'h01);
    check("to_park",   {7'd0, bus.tms_out}, 8'h01);
    ticks(4);
    check("to_sel_hold", {6'd0, bus.sel_tap_out}, 8'h00);
    tick();
    check("to_sel_flip", {6'd0, bus.sel_tap_out}, 8'h02);
    ticks(10);
    check("to_sticky", {7'd0, bus.forced_park}, 8'h01);

    // Abort from WAIT_SAFE by returning the strap to PHY.
    do_reset();
    goto_shdr();
    bus.pad_sel_tap = 2'b10;
    ticks(3);
    check("ab_busy", {7'd0, bus.busy}, 8'h01);
    bus.pad_sel_tap = 2'b00;
    ticks(2);
    check("ab_busy_hold", {7'd0, bus.busy}, 8'h01);
    tick();
    check("ab_busy_drop", {7'd0, bus.busy}, 8'h00);
    check("ab_tms",       {7'd0, bus.tms_out}, 8'h00);
    ticks(5);
    check("ab_sel",    {6'd0, bus.sel_tap_out}, 8'h00);
    check("ab_shadow", {4'd0, bus.shadow_state}, 8'h02);

    // Request during PARK, then reset mid-PARK of the follow-up switch.
    do_reset();
    tick();
    bus.pad_sel_tap = 2'b10;
    ticks(3);
    tick();
    check("rp_park", {7'd0, bus.tms_out}, 8'h01);
    bus.pad_sel_tap = 2'b00;
    ticks(5);
    check("rp_commit", {6'd0, bus.sel_tap_out}, 8'h02);
    check("rp_idle",   {7'd0, bus.busy}, 8'h00);
    tick();
    check("rp_restart", {7'd0, bus.busy}, 8'h01);
    wait_park(WAITM + 8);
    ticks(2);
    tap_trst_n = 1'b0;
    #1;
    check("rp_rst_tms", {7'd0, bus.tms_out}, 8'h01);
    tick();
    check("rp_rst_sel",    {6'd0, bus.sel_tap_out}, 8'h00);
    check("rp_rst_busy",   {7'd0, bus.busy}, 8'h00);
    check("rp_rst_shadow", {4'd0, bus.shadow_state}, 8'h0F);
    tap_trst_n = 1'b1;

    // Randomized traffic against the model; some blocks hold TMS low to hit timeouts.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 29) == 0) bus.pad_sel_tap = 2'($urandom_range(0, 3));
      case (mode)
        0: bus.pad_tap_tms = 1'($urandom_range(0, 1));
        1: bus.pad_tap_tms = ($urandom_range(0, 9) == 0);
        default: bus.pad_tap_tms = ($urandom_range(0, 3) != 0);
      endcase
      tap_trst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    tap_trst_n = 1'b1;
    bits = bus.sel_tap_out;
    check("final_sel_known", {7'd0, ^bits === 1'bx}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tap_sel_ctrl.md
Name: tap_sel_ctrl

Overview:
- Safe-switch sequencer for JTAG TAP selection. Sits between the pad-level TAP-select strap and the TAP IO mux.
- Drives the mux's TAP-select code and TMS, and shadows the active TAP state from TMS.
- On a select change, it waits for the active TAP to be quiescent, then forces TMS=1 so both TAPs park in Test-Logic-Reset. Only then does it flip the select.
- This prevents a TAP from being orphaned mid-shift when the strap toggles.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on pad_sel_tap (allowed range 2..4).
- PARK_CYCLES, 5, number of tck cycles TMS is forced high before commit (minimum 5).
- WAIT_MAX, 64, tck cycles to wait for a safe shadow state before forcing park.

Ports:
- tap_tck  in  1  TAP clock; the only clock.
- tap_trst_n  in  1  reset, synchronous, active-low.
- pad_sel_tap  in  2  requested TAP select, asynchronous strap.
- pad_tap_tms  in  1  host TMS from pad.
- sel_tap_out  out  2  select code to the mux. 00 = PHY TAP, any other value = testchip TAP.
- tms_out  out  1  TMS to the mux (combinational).
- busy  out  1  switch in progress.
- forced_park  out  1  sticky; set when a park was forced by WAIT_MAX timeout.
- shadow_state  out  4  shadowed TAP state, IEEE 1149.1 encoding.

Behaviour:
- Reset (tap_trst_n=0 at a rising tap_tck edge) sets:
  - sel_tap_out=00, busy=0, forced_park=0, shadow_state=4'hF (TLR), FSM=ACTIVE, counters=0, synchroniser flops=00.
  - tms_out=1 combinationally whenever tap_trst_n=0.
- Synchroniser: pad_sel_tap passes through SYNC_STAGES flops to give sel_sync.
- Shadow FSM:
  - Standard 16-state TAP transitions, advanced each rising edge on tms_out (the value the TAPs actually see).
  - Encodings: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- tms_out: equals pad_tap_tms in ACTIVE and WAIT_SAFE; equals 1 in PARK.
- Request classes: class(x) = (x != 00).
  - sel_sync != sel_tap_out with the same class: sel_tap_out <= sel_sync next edge. No park, busy stays 0 (mux routing is unchanged).
  - Class differs: ACTIVE -> WAIT_SAFE; latch target <= sel_sync; busy=1; wait counter cleared.
- WAIT_SAFE, evaluated each edge in this priority:
  1. class(sel_sync) == class(sel_tap_out): abort -> ACTIVE, busy=0, no park.
  2. Shadow is TLR or RTI (registered value): -> PARK.
  3. Wait counter == WAIT_MAX-1: -> PARK and set forced_park.
  4. Otherwise increment the wait counter.
- PARK:
  - Counter runs 0..PARK_CYCLES-1 with tms_out=1. The request is not re-sampled and there is no abort.
  - On the last cycle: sel_tap_out <= latched target, shadow <= F, state -> ACTIVE, busy <= 0.
  - Latency from entering PARK to the select flip is exactly PARK_CYCLES edges.
- A sel_sync change during PARK is ignored until ACTIVE. ACTIVE then detects any mismatch on the next edge and starts a new switch.
- Reset asserted mid-WAIT_SAFE or mid-PARK: immediate return to reset values. sel_tap_out reverts to 00 even if it was previously testchip.
- forced_park is cleared only by reset.
- sel_tap_out changes only in ACTIVE (same-class update) or on the PARK exit edge. It never glitches otherwise.

Test Plan:
- Idle-switch: reset, hold TMS=0 (shadow C), set pad_sel_tap 00->10. Expected:
  - busy rises SYNC_STAGES+1 edges later.
  - PARK follows next edge; tms_out=1 for 5 edges.
  - sel_tap_out=10 and busy=0 on the 5th PARK edge; shadow_state=F; forced_park=0.
- Mid-shift: drive the shadow to ShDR (2), hold TMS=0, request 00->01. Expected:
  - busy=1 and tms_out follows pad_tap_tms.
  - With TMS pattern 1,1,0 (Ex1DR->UpdDR->RTI), PARK starts on the edge after shadow reaches C.
  - Select flips 5 edges later.
- Timeout: hold the shadow in ShDR, request 00->10, with WAIT_MAX=64. Expected: PARK is entered after 64 WAIT_SAFE edges, forced_park=1 and sticky, and sel_tap_out=10 after 5 more edges.
- Abort and same-class:
  - From WAIT_SAFE (shadow 2), return pad_sel_tap to 00 → ACTIVE, busy=0, no forced TMS.
  - Separately, with sel=10 active, change pad_sel_tap to 01 → sel_tap_out=01 after SYNC_STAGES+1 edges, busy never rises.
- Request during PARK and reset: while in PARK (00->10), change pad_sel_tap to 00. Expected:
  - The commit to 10 completes, then a new switch back to 00 starts.
  - Asserting tap_trst_n=0 on PARK cycle 3 gives sel_tap_out=00, tms_out=1, busy=0, shadow F at the next edge.
- Shadow coverage: drive a TMS sequence visiting all 16 states. Expected: shadow_state matches the 1149.1 reference model every edge, and five consecutive TMS=1 from any state yields F.
